hcf_arbiter_ctrl: RTL and testbench
===================================

Name: hcf_arbiter_ctrl

Overview:
- Shared, sequential subtractive HCF (GCD) engine serving NREQ requesters.
- Contains a round-robin arbiter, an operand-capture FSM, and one W-bit compare/subtract datapath that performs one subtraction per clock.
- Results return on a valid/ready channel tagged with the requester ID.
- Sits between several HCF clients and replaces per-client combinational HCF instances; zero operands are handled explicitly, so the engine never loops unbounded.

Parameters:
- W, 8, operand and result width in bits.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the requester ID; must equal clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; operands must be stable while req is high.
- a_in  input  NREQ*W  operand A; requester i uses bits [i*W +: W].
- b_in  input  NREQ*W  operand B; same packing as a_in.
- ack  output  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_id  output  IDW  ID of the requester owning the result.
- hcf_out  output  W  HCF result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, ptr=0, x=0, y=0, ack=0, res_valid=0, res_id=0, hcf_out=0, busy=0.
- FSM states are IDLE, RUN and DONE.
- IDLE transition:
  - Triggered by any req bit set at a clock edge.
  - Grant the first set req[i] searching ptr, ptr+1, …, wrapping mod NREQ.
  - Capture operands into x and y, latch id=i, set ptr=(i+1) mod NREQ.
  - ack[i] is high for exactly the following cycle.
  - Next state is RUN.
- Zero operands at capture:
  - a==0 loads x=y=b.
  - b==0 loads x=y=a.
  - Both zero load x=y=0.
  - Otherwise x=a, y=b.
- RUN, evaluated once per edge:
  - x>y: x<=x-y.
  - y>x: y<=y-x.
  - x==y: go to DONE, drive hcf_out=x and res_id=id, assert res_valid.
- Arithmetic is unsigned, width W. The subtraction never underflows because the smaller value is always subtracted.
- Latency: res_valid rises S+1 cycles after the capture edge, where S is the number of subtractions. For W=8 the worst case is S=254 (operands 255 and 1).
- DONE: res_valid, hcf_out and res_id are held stable until an edge where res_valid && res_ready; that edge clears res_valid and returns the FSM to IDLE.
- No new capture occurs in the handshake cycle. The earliest next capture is the following edge.
- req and ack timing:
  - req is ignored outside IDLE.
  - A requester still asserting req when the FSM re-enters IDLE is treated as a new request.
  - Requesters drop req, or change operands, after seeing ack.
- Fairness: with all req bits held high, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 other jobs.
- Reset mid-operation: all state clears immediately (asynchronous), any in-flight job is discarded with no result, and ptr returns to 0.
- Simultaneous events in IDLE: only one grant per edge, chosen by the rotating priority.
- busy=1 in RUN and DONE.

Test Plan:
- Single requester: req[0]=1, a=12, b=18 -> ack[0] pulses; res_valid after 3 cycles (S=2); hcf_out=6, res_id=0.
- Zero cases:
  - a=0, b=45 -> hcf_out=45, latency 1.
  - a=0, b=0 -> hcf_out=0, latency 1.
  - a=45, b=45 -> hcf_out=45, latency 1.
- Worst case: a=255, b=1 -> hcf_out=1 with res_valid exactly 255 cycles after capture; busy is high throughout.
- Round-robin: all 4 req held, res_ready=1, operands (i+1)*6 and 36 -> grant order 0,1,2,3,0; res_id matches; hcf_out 6,12,18 and 12 (for i=3, (i+1)*6=24, HCF(24,36)=12).
- Backpressure: res_ready=0 for 5 cycles after res_valid -> hcf_out, res_id and res_valid stable, state stays DONE, no ack pulses, no new grant; release leads to IDLE.
- Reset in RUN: assert rst during a 255/1 job -> outputs reset the same cycle; with req[2] still high after reset, it is granted first from ptr=0 search and the correct result returns.

Source files
------------

// File: rtl/hcf_arbiter_ctrl_if.sv
// hcf_arbiter_ctrl_if: request/operand and tagged-result bundle between HCF clients and the shared engine.
interface hcf_arbiter_ctrl_if #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      hcf_out;
    logic              busy;
    modport master (
        output req, a_in, b_in, res_ready,
        input  ack, res_valid, res_id, hcf_out, busy
    );
    modport slave (
        input  req, a_in, b_in, res_ready,
        output ack, res_valid, res_id, hcf_out, busy
    );
endinterface

// File: rtl/hcf_arbiter_ctrl.sv
// hcf_arbiter_ctrl: round-robin arbitrated, one-subtraction-per-cycle HCF engine shared by NREQ clients.
module hcf_arbiter_ctrl #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic              clk,
    input logic              rst,
    hcf_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    hcf_q, hcf_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            res_valid_q, res_valid_d;
    logic            found;
    logic [IDW-1:0]  gnt;
    logic [IDW:0]    idx;
    logic [W-1:0]    a_sel, b_sel;

    // Rotating-priority search starting at ptr; idx is one bit wider so the wrap works for any NREQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (IDW+1)'(ptr_q) + (IDW+1)'(k);
            idx = (idx >= (IDW+1)'(NREQ)) ? idx - (IDW+1)'(NREQ) : idx;
            if (!found && bus.req[IDW'(idx)]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    assign a_sel = bus.a_in[gnt*W +: W];
    assign b_sel = bus.b_in[gnt*W +: W];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        res_id_d    = res_id_q;
        x_d         = x_q;
        y_d         = y_q;
        hcf_d       = hcf_q;
        ack_d       = '0;
        res_valid_d = res_valid_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = RUN;
                id_d    = gnt;
                ptr_d   = (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
                // A zero operand collapses the job to the other operand, so RUN finishes at once.
                x_d     = (a_sel == '0) ? b_sel : a_sel;
                y_d     = (b_sel == '0) ? a_sel : b_sel;
                ack_d   = NREQ'(1) << gnt;
            end
        end else if (state_q == RUN) begin
            if (x_q > y_q) begin
                x_d = x_q - y_q;
            end else if (y_q > x_q) begin
                y_d = y_q - x_q;
            end else begin
                state_d     = DONE;
                hcf_d       = x_q;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
            end
        end else if (bus.res_ready) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            res_id_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            hcf_q       <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            res_id_q    <= res_id_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hcf_q       <= hcf_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.hcf_out   = hcf_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_hcf_arbiter_ctrl.sv
// tb_hcf_arbiter_ctrl: directed stimulus with a job-level reference model compared every cycle.
module tb_hcf_arbiter_ctrl;
    localparam int W = 8, NREQ = 4, IDW = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0, n_err = 0;

    hcf_arbiter_ctrl_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus();
    hcf_arbiter_ctrl #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Euclid by division: result and number of subtractions the subtractive method needs.
    function automatic void ref_job(input int a, input int b, output int g, output int s);
        int p, q, r, sum;
        if (a == 0 || b == 0) begin
            g = a + b;
            s = 0;
        end else begin
            p = (a > b) ? a : b;
            q = (a > b) ? b : a;
            sum = 0;
            while (q != 0) begin
                sum += p / q;
                r = p % q;
                p = q;
                q = r;
            end
            g = p;
            s = sum - 1;
        end
    endfunction

    logic [NREQ-1:0] m_ack;
    bit m_busy, m_valid;
    int m_left, m_hcf, m_id, m_ptr, m_cur, m_g;

    // Job-level model: a grant starts a countdown of S+1 edges, then the result waits for res_ready.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack = '0; m_busy = 0; m_valid = 0; m_left = 0;
            m_hcf = 0; m_id = 0; m_ptr = 0;
        end else begin
            m_ack = '0;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (!m_busy && bus.req[i]) begin
                        int s;
                        m_busy = 1;
                        m_ack[i] = 1'b1;
                        m_cur = i;
                        m_ptr = (i + 1) % NREQ;
                        ref_job(int'(bus.a_in[i*W +: W]), int'(bus.b_in[i*W +: W]), m_g, s);
                        m_left = s + 1;
                    end
                end
            end else if (m_valid) begin
                if (bus.res_ready) begin
                    m_valid = 0;
                    m_busy = 0;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1;
                    m_hcf = m_g;
                    m_id = m_cur;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_ack", 32'(bus.ack), 32'(m_ack));
            check("model_busy", 32'(bus.busy), 32'(m_busy));
            check("model_valid", 32'(bus.res_valid), 32'(m_valid));
            if (m_valid) begin
                check("model_hcf", 32'(bus.hcf_out), 32'(m_hcf));
                check("model_id", 32'(bus.res_id), 32'(m_id));
            end
        end
    end

    // Called on a negedge; returns on the negedge where res_valid is first seen.
    task automatic run_job(input int idx, input int a, input int b, input int exp_h, input int exp_lat);
        int lat;
        bus.req[idx] = 1'b1;
        bus.a_in[idx*W +: W] = W'(a);
        bus.b_in[idx*W +: W] = W'(b);
        @(posedge clk); @(negedge clk);
        check("ack", 32'(bus.ack), 32'(1) << idx);
        bus.req[idx] = 1'b0;
        lat = 0;
        while (!bus.res_valid && lat < 400) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("hcf_out", 32'(bus.hcf_out), 32'(exp_h));
        check("res_id", 32'(bus.res_id), 32'(idx));
    endtask

    task automatic retire();
        @(posedge clk); @(negedge clk);
        check("retire_valid", 32'(bus.res_valid), 32'd0);
        check("retire_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_ack"}, 32'(bus.ack), 32'd0);
        check({tag, "_hcf"}, 32'(bus.hcf_out), 32'd0);
        check({tag, "_id"}, 32'(bus.res_id), 32'd0);
    endtask

    initial begin
        int g, s, w;
        int exp_rr[5] = '{6, 12, 18, 12, 6};
        bus.req = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.res_ready = 1'b1;
        #1 rst = 1'b1;
        #1 reset_outputs("reset");

        ref_job(12, 18, g, s);
        check("ref_12_18_g", 32'(g), 32'd6);
        check("ref_12_18_s", 32'(s), 32'd2);
        ref_job(255, 1, g, s);
        check("ref_255_1_s", 32'(s), 32'd254);
        ref_job(24, 36, g, s);
        check("ref_24_36_g", 32'(g), 32'd12);

        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        run_job(0, 12, 18, 6, 3);   retire();
        run_job(1, 0, 45, 45, 1);   retire();
        run_job(2, 0, 0, 0, 1);     retire();
        run_job(3, 45, 45, 45, 1);  retire();
        run_job(0, 255, 1, 1, 255); retire();

        // Backpressure with a competing request arriving while DONE.
        bus.res_ready = 1'b0;
        run_job(0, 20, 8, 4, 4);
        bus.req[1] = 1'b1;
        bus.a_in[1*W +: W] = 8'd9;
        bus.b_in[1*W +: W] = 8'd6;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_hcf", 32'(bus.hcf_out), 32'd4);
            check("bp_id", 32'(bus.res_id), 32'd0);
            check("bp_ack", 32'(bus.ack), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("hs_valid", 32'(bus.res_valid), 32'd0);
        check("hs_busy", 32'(bus.busy), 32'd0);
        check("hs_ack", 32'(bus.ack), 32'd0);
        run_job(1, 9, 6, 3, 3);     retire();

        // Round robin from a freshly reset pointer with every requester asserting.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.a_in[i*W +: W] = W'((i + 1) * 6);
            bus.b_in[i*W +: W] = 8'd36;
        end
        bus.req = '1;
        for (int j = 0; j < 5; j++) begin
            w = 0;
            while (bus.ack == '0 && w < 20) begin
                @(posedge clk); @(negedge clk);
                w++;
            end
            check("rr_grant", 32'(bus.ack), 32'(1) << (j % NREQ));
            if (j == 4) bus.req = '0;
            w = 0;
            while (!bus.res_valid && w < 400) begin
                @(posedge clk); @(negedge clk);
                w++;
            end
            check("rr_id", 32'(bus.res_id), 32'(j % NREQ));
            check("rr_hcf", 32'(bus.hcf_out), 32'(exp_rr[j]));
        end
        retire();

        // Reset during a long job; a pending higher-index request must lose to the ptr=0 search.
        bus.req[2] = 1'b1;
        bus.a_in[2*W +: W] = 8'd255;
        bus.b_in[2*W +: W] = 8'd1;
        @(posedge clk); @(negedge clk);
        check("rst_job_ack", 32'(bus.ack), 32'd4);
        bus.req[3] = 1'b1;
        bus.a_in[3*W +: W] = 8'd24;
        bus.b_in[3*W +: W] = 8'd36;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_job(2, 255, 1, 1, 255);
        retire();
        run_job(3, 24, 36, 12, 3);
        retire();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
